// File: rtl/tc_sram_handshake.sv
// tc_sram_handshake: valid/ready front end for a fixed-latency single-port tc_sram with credit-protected response FIFO
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           request handshake (req_we_i, req_addr_i, req_wdata_i, req_be_i)
//   rsp_valid_o/rsp_ready_i           read response handshake (rsp_rdata_o, zero while not valid)
//   sram_req_o .. sram_be_o           SRAM port 0 request, sram_rdata_i its read data
// Optional: define TC_SRAM_HANDSHAKE_BYPASS_EN to forward SRAM data straight to the output while the FIFO is empty.
module tc_sram_handshake #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 2,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);
    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [CntWidth-1:0]  cnt, fill;
    logic [PtrWidth-1:0]  wptr, rptr;
    logic [Latency-1:0]   trk;
    logic [DataWidth-1:0] mem [RspDepth];
    logic [DataWidth-1:0] rsp_data;
    logic                 rd_acc, rsp_hs, sram_vld, fifo_empty, push, pop, rsp_valid;

    // Credits count reads in flight plus FIFO entries, so a granted read always has a FIFO slot.
    assign req_ready_o  = !rst_i && (cnt < CntWidth'(RspDepth));
    assign sram_req_o   = req_valid_i && req_ready_o;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;
    assign rd_acc       = sram_req_o && !req_we_i;
    assign sram_vld     = trk[Latency-1];
    assign fifo_empty   = (fill == '0);

`ifdef TC_SRAM_HANDSHAKE_BYPASS_EN
    // Data arriving into an empty FIFO is presented directly and only stored if not taken.
    assign rsp_valid = !fifo_empty || sram_vld;
    assign rsp_data  = fifo_empty ? sram_rdata_i : mem[rptr];
    assign push      = sram_vld && !(fifo_empty && rsp_ready_i);
    assign pop       = !fifo_empty && rsp_ready_i;
`else
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = mem[rptr];
    assign push      = sram_vld;
    assign pop       = !fifo_empty && rsp_ready_i;
`endif

    assign rsp_valid_o = rsp_valid;
    assign rsp_rdata_o = rsp_valid ? rsp_data : '0;
    assign rsp_hs      = rsp_valid && rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt  <= '0;
            fill <= '0;
            wptr <= '0;
            rptr <= '0;
            trk  <= '0;
        end else begin
            cnt  <= cnt + CntWidth'(rd_acc) - CntWidth'(rsp_hs);
            fill <= fill + CntWidth'(push) - CntWidth'(pop);
            trk  <= (trk << 1) | Latency'(rd_acc);
            // Pointers wrap explicitly so non-power-of-two depths work.
            if (push) wptr <= (wptr == PtrWidth'(RspDepth - 1)) ? '0 : wptr + PtrWidth'(1);
            if (pop) rptr <= (rptr == PtrWidth'(RspDepth - 1)) ? '0 : rptr + PtrWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= sram_rdata_i;
    end
endmodule

// File: tb/tb_tc_sram_handshake.sv
// tb_tc_sram_handshake: directed and random checks of tc_sram_handshake against a behavioural SRAM and scoreboard
module tb_tc_sram_handshake;
    localparam int LAT   = 2;
    localparam int DEPTH = 3;
`ifdef TC_SRAM_HANDSHAKE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [5:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        sram_req_o, sram_we_o;
    logic [5:0]  sram_addr_o;
    logic [31:0] sram_wdata_o, sram_rdata_i;
    logic [3:0]  sram_be_o;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int hold_err = 0;
    logic        pend = 0;
    logic [31:0] pend_d = 0;
    logic [31:0] got_d[$];
    int          got_c[$];
    logic [31:0] smem [64];
    logic [31:0] pipe [LAT];
    logic [31:0] ref_mem [16];

    tc_sram_handshake #(.NumWords(64), .Latency(LAT), .RspDepth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // Behavioural SRAM: read data appears LAT cycles after the request, junk otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_req_o && sram_we_o) smem[sram_addr_o] <= merge(smem[sram_addr_o], sram_wdata_o, sram_be_o);
        pipe[0] <= (sram_req_o && !sram_we_o) ? smem[sram_addr_o] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_rdata_i = pipe[LAT-1];

    // Response monitor: logs handshakes and counts valid/data drops while stalled.
    always @(negedge clk) begin
        if (rst_i) begin
            pend <= 0;
        end else begin
            if (rsp_valid_o && rsp_ready_i) begin
                got_d.push_back(rsp_rdata_o);
                got_c.push_back(cyc);
            end
            if (pend && (!rsp_valid_o || rsp_rdata_o !== pend_d)) hold_err <= hold_err + 1;
            pend   <= rsp_valid_o && !rsp_ready_i;
            pend_d <= rsp_rdata_o;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rsp();
        got_d.delete();
        got_c.delete();
    endtask

    task automatic do_req(input logic we, input int addr, input logic [31:0] d, input logic [3:0] be, output int t);
        req_valid_i = 1;
        req_we_i    = we;
        req_addr_i  = 6'(addr);
        req_wdata_i = d;
        req_be_i    = be;
        t = -1;
        for (int i = 0; i < 50 && t < 0; i++) begin
            if (req_ready_o) t = cyc;
            step(1);
        end
        req_valid_i = 0;
        n_cmp++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL req_timeout: request to addr %0d not accepted within 50 cycles", addr);
        end
    endtask

    task automatic issue_reads(input int base, input int n, input int budget, output int acc);
        acc = 0;
        req_valid_i = 1;
        req_we_i    = 0;
        for (int i = 0; i < budget && acc < n; i++) begin
            req_addr_i = 6'(base + acc);
            if (req_ready_o) acc++;
            step(1);
        end
        req_valid_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        req_valid_i = 1;
        req_we_i = 0;
        step(3);
        n_cmp += 4;
        if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", req_ready_o); end
        if (sram_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_sram_req: got %b expected 0", sram_req_o); end
        if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid_o); end
        if (rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata_o); end
        rst_i = 0;
        req_valid_i = 0;
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", req_ready_o); end
        step(1);
    endtask

    task automatic test_basic();
        int t, tr;
        rsp_ready_i = 1;
        clear_rsp();
        do_req(1, 5, 32'hDEADBEEF, 4'hF, t);
        do_req(0, 5, 32'h0, 4'h0, tr);
        step(8);
        n_cmp += 3;
        if (got_d.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d responses expected 1", got_d.size()); end
        if (got_d.size() > 0 && got_d[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_data: got %h expected deadbeef", got_d[0]); end
        if (got_c.size() > 0 && got_c[0] - tr !== LAT + 1 - BYP) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", got_c[0] - tr, LAT + 1 - BYP); end
    endtask

    task automatic test_partial();
        int t;
        clear_rsp();
        do_req(1, 7, 32'hFFFFFFFF, 4'hF, t);
        do_req(1, 7, 32'h11223344, 4'b0101, t);
        do_req(0, 7, 32'h0, 4'h0, t);
        step(8);
        n_cmp += 2;
        if (got_d.size() !== 1) begin n_fail++; $display("FAIL partial_count: got %0d expected 1", got_d.size()); end
        if (got_d.size() > 0 && got_d[0] !== 32'hFF22FF44) begin n_fail++; $display("FAIL partial_data: got %h expected ff22ff44", got_d[0]); end
    endtask

    task automatic test_rbw();
        int t;
        do_req(1, 3, 32'hA, 4'hF, t);
        clear_rsp();
        do_req(0, 3, 32'h0, 4'h0, t);
        do_req(1, 3, 32'hB, 4'hF, t);
        do_req(0, 3, 32'h0, 4'h0, t);
        step(8);
        n_cmp += 3;
        if (got_d.size() !== 2) begin n_fail++; $display("FAIL rbw_count: got %0d expected 2", got_d.size()); end
        if (got_d.size() > 0 && got_d[0] !== 32'hA) begin n_fail++; $display("FAIL rbw_old: got %h expected 0000000a", got_d[0]); end
        if (got_d.size() > 1 && got_d[1] !== 32'hB) begin n_fail++; $display("FAIL rbw_new: got %h expected 0000000b", got_d[1]); end
    endtask

    task automatic test_backpressure();
        int t, acc;
        for (int a = 0; a < 6; a++) do_req(1, a, 32'h10 + a, 4'hF, t);
        step(4);
        clear_rsp();
        rsp_ready_i = 0;
        issue_reads(0, 6, 20, acc);
        n_cmp += 5;
        if (acc !== DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH); end
        if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", req_ready_o); end
        if (got_d.size() !== 0) begin n_fail++; $display("FAIL bp_no_rsp: got %0d expected 0", got_d.size()); end
        if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", rsp_valid_o); end
        if (rsp_rdata_o !== 32'h10) begin n_fail++; $display("FAIL bp_head: got %h expected 00000010", rsp_rdata_o); end
        rsp_ready_i = 1;
        issue_reads(DEPTH, 6 - DEPTH, 50, acc);
        for (int i = 0; i < 40 && got_d.size() < 6; i++) step(1);
        n_cmp += 2;
        if (acc !== 6 - DEPTH) begin n_fail++; $display("FAIL bp_rest: got %0d expected %0d", acc, 6 - DEPTH); end
        if (got_d.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got_d.size()); end
        for (int i = 0; i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== 32'h10 + i) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_d[i], 32'h10 + i); end
        end
    endtask

    task automatic test_reset_flight();
        int acc;
        rsp_ready_i = 0;
        clear_rsp();
        issue_reads(0, 3, 10, acc);
        n_cmp += 2;
        if (acc !== 3) begin n_fail++; $display("FAIL rf_issue: got %0d expected 3", acc); end
        if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rf_pre_valid: got %b expected 1", rsp_valid_o); end
        rst_i = 1;
        step(1);
        n_cmp++;
        if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rf_rst_valid: got %b expected 0", rsp_valid_o); end
        step(1);
        rst_i = 0;
        #1;
        clear_rsp();
        n_cmp += 2;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rf_ready: got %b expected 1", req_ready_o); end
        if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b expected 0", rsp_valid_o); end
        rsp_ready_i = 1;
        step(6);
        n_cmp++;
        if (got_d.size() !== 0) begin n_fail++; $display("FAIL rf_discard: got %0d responses expected 0", got_d.size()); end
        rsp_ready_i = 0;
        issue_reads(0, 6, 12, acc);
        n_cmp++;
        if (acc !== DEPTH) begin n_fail++; $display("FAIL rf_credits: got %0d expected %0d", acc, DEPTH); end
        rsp_ready_i = 1;
        step(10);
        clear_rsp();
    endtask

    task automatic test_stress();
        logic [31:0] exp_q[$];
        logic [31:0] d, e;
        int ops, t;
        ops = 0;
        rsp_ready_i = 1;
        step(6);
        clear_rsp();
        for (int a = 0; a < 16; a++) begin
            d = $urandom;
            ref_mem[a] = d;
            do_req(1, a, d, 4'hF, t);
        end
        for (int i = 0; i < 60000 && ops < 10000; i++) begin
            while (got_d.size() > 0) begin
                d = got_d.pop_front();
                void'(got_c.pop_front());
                e = (exp_q.size() > 0) ? exp_q.pop_front() : ~d;
                n_cmp++;
                if (d !== e) begin n_fail++; $display("FAIL stress_data: got %h expected %h", d, e); end
            end
            n_cmp++;
            if (req_ready_o !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL stress_ready: got %b expected %b", req_ready_o, exp_q.size() < DEPTH); end
            req_valid_i = $urandom_range(0, 3) != 0;
            req_we_i    = $urandom_range(0, 2) == 0;
            req_addr_i  = 6'($urandom_range(0, 15));
            req_wdata_i = $urandom;
            req_be_i    = 4'($urandom);
            rsp_ready_i = $urandom_range(0, 2) != 0;
            #1;
            n_cmp++;
            if (sram_req_o !== (req_valid_i && req_ready_o)) begin n_fail++; $display("FAIL stress_sram_req: got %b expected %b", sram_req_o, req_valid_i && req_ready_o); end
            if (req_valid_i && req_ready_o) begin
                ops++;
                if (req_we_i) ref_mem[req_addr_i[3:0]] = merge(ref_mem[req_addr_i[3:0]], req_wdata_i, req_be_i);
                else exp_q.push_back(ref_mem[req_addr_i[3:0]]);
            end
            @(posedge clk);
            #1;
        end
        req_valid_i = 0;
        rsp_ready_i = 1;
        for (int i = 0; i < 40; i++) begin
            while (got_d.size() > 0) begin
                d = got_d.pop_front();
                void'(got_c.pop_front());
                e = (exp_q.size() > 0) ? exp_q.pop_front() : ~d;
                n_cmp++;
                if (d !== e) begin n_fail++; $display("FAIL stress_drain_data: got %h expected %h", d, e); end
            end
            step(1);
        end
        n_cmp += 3;
        if (ops !== 10000) begin n_fail++; $display("FAIL stress_ops: got %0d expected 10000", ops); end
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stress_missing: got %0d outstanding expected 0", exp_q.size()); end
        if (hold_err !== 0) begin n_fail++; $display("FAIL stress_hold: got %0d stability violations expected 0", hold_err); end
    endtask

    initial begin
        rst_i = 1;
        req_valid_i = 0;
        req_we_i = 0;
        req_addr_i = 0;
        req_wdata_i = 0;
        req_be_i = 0;
        rsp_ready_i = 0;
        #1;
        test_reset();
        test_basic();
        test_partial();
        test_rbw();
        test_backpressure();
        test_reset_flight();
        test_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
